// File: rtl/decode_stage.sv
// Registered RV32I decoder between fetch and regfile/execute; DECODE_RV32M_EN enables MULDIV decode.
// Latency: an accepted beat appears on out_* one cycle later when the main register is empty or draining.
// Backpressure: a 2-entry main+skid buffer keeps in_ready registered and sustains 1 instruction/cycle.
module decode_stage #(
    parameter int PC_W  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_oper,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [31:0]      out_imm,
    output logic             out_we,
    output logic             out_illegal,
    output logic [PC_W-1:0]  out_pc,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] CLS_ALU    = 4'd0;
    localparam logic [3:0] CLS_ALUIMM = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_JAL    = 4'd5;
    localparam logic [3:0] CLS_JALR   = 4'd6;
    localparam logic [3:0] CLS_UPPER  = 4'd7;
    localparam logic [3:0] CLS_ILL    = 4'd15;
`ifdef DECODE_RV32M_EN
    localparam logic [6:0] F7_MUL     = 7'b0000001;
    localparam logic [3:0] CLS_MULDIV = 4'd8;
`endif

    typedef struct packed {
        logic [7:0]       oper;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [31:0]      imm;
        logic             we;
        logic             illegal;
        logic [PC_W-1:0]  pc;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // Instruction fields and the five immediate formats, all sign-extended from bit 31.
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_f;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign rd_f   = in_inst[11:7];
    assign rs1_f  = in_inst[19:15];
    assign rs2_f  = in_inst[24:20];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'h000};
    assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // Control decode: class, alt bit, legality and which fields the format uses.
    logic [3:0]  cls;
    logic [2:0]  sub_op;
    logic [31:0] imm_sel;
    logic        alt;
    logic        legal;
    logic        wr_cls;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;

    // Classify the opcode and validate funct7 against funct3 where the encoding restricts it.
    always_comb begin
        cls     = CLS_ILL;
        sub_op  = f3;
        imm_sel = 32'd0;
        alt     = 1'b0;
        legal   = 1'b1;
        wr_cls  = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_ALU: begin
                cls     = CLS_ALU;
                wr_cls  = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (f7 == F7_ALT) begin
                    alt   = 1'b1;
                    legal = (f3 == 3'b000) || (f3 == 3'b101);
                end
`ifdef DECODE_RV32M_EN
                else if (f7 == F7_MUL) begin
                    cls = CLS_MULDIV;
                end
`endif
                else begin
                    legal = (f7 == F7_BASE);
                end
            end
            OP_IMM: begin
                cls     = CLS_ALUIMM;
                wr_cls  = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm_sel = imm_i;
                if (f3 == 3'b001) begin
                    legal = (f7 == F7_BASE);
                end else if (f3 == 3'b101) begin
                    alt   = (f7 == F7_ALT);
                    legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                end
            end
            OP_LOAD: begin
                cls     = CLS_LOAD;
                wr_cls  = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm_sel = imm_i;
            end
            OP_STORE: begin
                cls     = CLS_STORE;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_sel = imm_s;
            end
            OP_BRANCH: begin
                cls     = CLS_BRANCH;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_sel = imm_b;
            end
            OP_JAL: begin
                cls     = CLS_JAL;
                sub_op  = 3'b000;
                wr_cls  = 1'b1;
                use_rd  = 1'b1;
                imm_sel = imm_j;
            end
            OP_JALR: begin
                cls     = CLS_JALR;
                wr_cls  = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm_sel = imm_i;
            end
            OP_LUI, OP_AUIPC: begin
                cls     = CLS_UPPER;
                sub_op  = {2'b00, (opcode == OP_AUIPC)};
                wr_cls  = 1'b1;
                use_rd  = 1'b1;
                imm_sel = imm_u;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Assemble the decoded entry; illegal encodings collapse to class 15 with zeroed fields.
    entry_t dec;
    always_comb begin
        dec     = '0;
        dec.pc  = in_pc;
        dec.tag = in_tag;
        if (legal) begin
            dec.oper = {cls, alt, sub_op};
            dec.rd   = use_rd  ? rd_f  : 5'd0;
            dec.rs1  = use_rs1 ? rs1_f : 5'd0;
            dec.rs2  = use_rs2 ? rs2_f : 5'd0;
            dec.imm  = imm_sel;
            dec.we   = wr_cls && (rd_f != 5'd0);
        end else begin
            dec.oper    = {CLS_ILL, 4'b0000};
            dec.illegal = 1'b1;
        end
    end

    // Main register M drives the outputs; skid register S absorbs the beat accepted while M stalls.
    entry_t m_q, m_d, s_q, s_d;
    logic   m_vld_q, m_vld_d;
    logic   s_vld_q, s_vld_d;
    logic   in_ready_q, in_ready_d;
    logic   acc;
    logic   xfer;

    assign acc  = in_valid && in_ready_q;
    assign xfer = m_vld_q && out_ready;

    // Buffer steering: refill M from S first to keep order; flush overrides everything.
    always_comb begin
        m_d     = m_q;
        s_d     = s_q;
        m_vld_d = m_vld_q;
        s_vld_d = s_vld_q;
        if (flush) begin
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (!m_vld_q || xfer) begin
            if (s_vld_q) begin
                m_d     = s_q;
                m_vld_d = 1'b1;
                if (acc) begin
                    s_d = dec;
                end
                s_vld_d = acc;
            end else begin
                if (acc) begin
                    m_d = dec;
                end
                m_vld_d = acc;
            end
        end else if (acc) begin
            s_d     = dec;
            s_vld_d = 1'b1;
        end
        in_ready_d = !s_vld_d;
    end

    // State registers with asynchronous reset clearing both entries and their data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q        <= '0;
            s_q        <= '0;
            m_vld_q    <= 1'b0;
            s_vld_q    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            m_vld_q    <= m_vld_d;
            s_vld_q    <= s_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = m_vld_q;
    assign out_oper    = m_q.oper;
    assign out_rd      = m_q.rd;
    assign out_rs1     = m_q.rs1;
    assign out_rs2     = m_q.rs2;
    assign out_imm     = m_q.imm;
    assign out_we      = m_q.we;
    assign out_illegal = m_q.illegal;
    assign out_pc      = m_q.pc;
    assign out_tag     = m_q.tag;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed RV32I words against a queue-based reference model.
// Model holds expected entries in order; in_ready/out_valid follow from its occupancy.
// Compare runs every negedge outside reset; literal expectations pin the model.
module tb_decode_stage;
    localparam int PC_W  = 32;
    localparam int TAG_W = 4;
`ifdef DECODE_RV32M_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [PC_W-1:0]  in_pc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_oper;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [31:0]      out_imm;
    logic             out_we;
    logic             out_illegal;
    logic [PC_W-1:0]  out_pc;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    decode_stage #(.PC_W(PC_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_oper(out_oper), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_imm(out_imm), .out_we(out_we),
        .out_illegal(out_illegal), .out_pc(out_pc), .out_tag(out_tag)
    );

    typedef struct packed {
        logic [7:0]  oper;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        we;
        logic        ill;
        logic [31:0] pc;
        logic [3:0]  tag;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    bit   m_acc;
    bit   m_xfer;
    bit   tail_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference decode written from the ISA tables: pick class and format, then fill fields.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc,
                                   input logic [3:0] tag);
        exp_t       e;
        logic [3:0] cls;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         alt;
        bit         ok;
        int         fmt; // 0 R, 1 I, 2 S, 3 B, 4 U, 5 J
        int         v;
        e   = '0;
        e.pc  = pc;
        e.tag = tag;
        f3  = w[14:12];
        f7  = w[31:25];
        alt = 1'b0;
        ok  = 1'b1;
        cls = 4'd15;
        fmt = 0;
        case (w[6:0])
            7'b0110011: begin
                fmt = 0;
                if (f7 == 7'b0000000) cls = 4'd0;
                else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    cls = 4'd0;
                    alt = 1'b1;
                end
                else if (f7 == 7'b0000001 && MEXT) cls = 4'd8;
                else ok = 1'b0;
            end
            7'b0010011: begin
                fmt = 1;
                cls = 4'd1;
                if (f3 == 3'd1 && f7 != 7'd0) ok = 1'b0;
                if (f3 == 3'd5) begin
                    if (f7 == 7'b0100000) alt = 1'b1;
                    else if (f7 != 7'd0) ok = 1'b0;
                end
            end
            7'b0000011: begin fmt = 1; cls = 4'd2; end
            7'b0100011: begin fmt = 2; cls = 4'd3; end
            7'b1100011: begin fmt = 3; cls = 4'd4; end
            7'b1101111: begin fmt = 5; cls = 4'd5; end
            7'b1100111: begin fmt = 1; cls = 4'd6; end
            7'b0110111, 7'b0010111: begin fmt = 4; cls = 4'd7; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.oper = 8'hF0;
            e.ill  = 1'b1;
            return e;
        end
        case (fmt)
            0: begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; end
            1: begin e.rd = w[11:7]; e.rs1 = w[19:15]; v = $signed(w[31:20]); e.imm = v; end
            2: begin
                e.rs1 = w[19:15]; e.rs2 = w[24:20];
                v = $signed({w[31:25], w[11:7]}); e.imm = v;
            end
            3: begin
                e.rs1 = w[19:15]; e.rs2 = w[24:20];
                v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0}); e.imm = v;
            end
            4: begin e.rd = w[11:7]; e.imm = {w[31:12], 12'h000}; end
            default: begin
                e.rd = w[11:7];
                v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0}); e.imm = v;
            end
        endcase
        if (cls == 4'd7)      e.oper = {4'd7, 3'b000, (w[6:0] == 7'b0010111)};
        else if (cls == 4'd5) e.oper = 8'h50;
        else                  e.oper = {cls, alt, f3};
        e.we = (cls != 4'd3) && (cls != 4'd4) && (w[11:7] != 5'd0);
        return e;
    endfunction

    task automatic pin(input string name, input logic [31:0] w, input logic [7:0] oper,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic we, input logic ill);
        exp_t e;
        e = model(w, 32'h0, 4'h0);
        chk({name, ".oper"}, e.oper, oper);
        chk({name, ".rd"},   e.rd,   rd);
        chk({name, ".rs1"},  e.rs1,  rs1);
        chk({name, ".rs2"},  e.rs2,  rs2);
        chk({name, ".imm"},  e.imm,  imm);
        chk({name, ".we"},   e.we,   we);
        chk({name, ".ill"},  e.ill,  ill);
    endtask

    // Model occupancy update on each edge, mirroring only the handshake contract.
    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            q.delete();
        end else begin
            m_acc  = in_valid && (q.size() < 2);
            m_xfer = (q.size() > 0) && out_ready;
            if (m_xfer) void'(q.pop_front());
            if (m_acc) q.push_back(model(in_inst, in_pc, in_tag));
        end
    end

    // Per-cycle comparison of DUT outputs with the model head.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", out_valid, (q.size() > 0));
            chk("in_ready", in_ready, (q.size() < 2));
            if (q.size() > 0 && out_valid) begin
                chk("oper", out_oper, q[0].oper);
                chk("rd", out_rd, q[0].rd);
                chk("rs1", out_rs1, q[0].rs1);
                chk("rs2", out_rs2, q[0].rs2);
                chk("imm", out_imm, q[0].imm);
                chk("we", out_we, q[0].we);
                chk("illegal", out_illegal, q[0].ill);
                chk("pc", out_pc, q[0].pc);
                chk("tag", out_tag, q[0].tag);
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic [31:0] pc, input logic [3:0] tag);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_inst  = w;
        in_pc    = pc;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [31:0] tbl [14];

    initial begin
        tbl = '{32'h002081B3, 32'h402081B3, 32'hFFF00293, 32'h00812303, 32'h00612623,
                32'hFE208EE3, 32'h008000EF, 32'h123452B7, 32'h00001397, 32'h00008067,
                32'h40325213, 32'hFFFFFFFF, 32'h4020C1B3, 32'h022081B3};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = 32'h0;
        in_pc = '0; in_tag = '0; out_ready = 1'b0; tail_done = 1'b0;

        // Pin the model against hand-decoded words.
        pin("add",   32'h002081B3, 8'h00, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b0);
        pin("sub",   32'h402081B3, 8'h08, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b0);
        pin("addi",  32'hFFF00293, 8'h10, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
        pin("lw",    32'h00812303, 8'h22, 5'd6, 5'd2, 5'd0, 32'd8, 1'b1, 1'b0);
        pin("sw",    32'h00612623, 8'h32, 5'd0, 5'd2, 5'd6, 32'd12, 1'b0, 1'b0);
        pin("beq",   32'hFE208EE3, 8'h40, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 1'b0);
        pin("jal",   32'h008000EF, 8'h50, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 1'b0);
        pin("lui",   32'h123452B7, 8'h70, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 1'b0);
        pin("auipc", 32'h00001397, 8'h71, 5'd7, 5'd0, 5'd0, 32'h00001000, 1'b1, 1'b0);
        pin("srai",  32'h40325213, 8'h1D, 5'd4, 5'd4, 5'd0, 32'h403, 1'b1, 1'b0);
        pin("allf",  32'hFFFFFFFF, 8'hF0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
        pin("xoralt",32'h4020C1B3, 8'hF0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
        pin("addx0", 32'h00208033, 8'h00, 5'd0, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0);
        if (MEXT) pin("mul", 32'h022081B3, 8'h80, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b0);
        else      pin("mul", 32'h022081B3, 8'hF0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.oper", out_oper, 8'h00);
        chk("rst.imm", out_imm, 32'h0);
        chk("rst.pc", out_pc, 32'h0);
        @(posedge clk); #1; rst = 1'b0;

        // First beat: one-cycle latency.
        out_ready = 1'b1;
        send(32'h002081B3, 32'h100, 4'h1);
        @(negedge clk);
        chk("lat.valid", out_valid, 1'b1);
        chk("lat.oper", out_oper, 8'h00);
        chk("lat.rd", out_rd, 5'd3);
        chk("lat.we", out_we, 1'b1);

        // Back-to-back stream of every class.
        @(posedge clk); #1;
        for (int i = 0; i < 14; i++) send(tbl[i], 32'h200 + 4 * i, i[3:0]);
        send(32'h00208033, 32'h300, 4'hE);
        repeat (3) @(posedge clk); #1;

        // Backpressure: two accepts fill M and S, third waits.
        out_ready = 1'b0;
        fork
            begin
                send(32'h00812303, 32'h400, 4'h2);
                send(32'h00612623, 32'h404, 4'h3);
                send(32'hFFF00293, 32'h408, 4'h4);
            end
            begin
                repeat (5) @(negedge clk);
                chk("bp.in_ready", in_ready, 1'b0);
                chk("bp.oper", out_oper, 8'h22);
                chk("bp.imm", out_imm, 32'd8);
                @(posedge clk); #1; out_ready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        chk("bp.ready_back", in_ready, 1'b1);

        // Flush with M and S full; offered beat is dropped.
        @(posedge clk); #1; out_ready = 1'b0;
        send(32'h002081B3, 32'h500, 4'h5);
        send(32'h402081B3, 32'h504, 4'h6);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00100093;
        @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl.valid", out_valid, 1'b0);
        chk("fl.ready", in_ready, 1'b1);

        // Flush with only M full while in_ready is high.
        @(posedge clk); #1;
        send(32'h008000EF, 32'h600, 4'h7);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h123452B7;
        @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("fl2.valid", out_valid, 1'b0);
        @(posedge clk); #1; out_ready = 1'b1;
        send(32'h00001397, 32'h700, 4'h8);
        send(32'h00008067, 32'h704, 4'h9);
        repeat (3) @(posedge clk); #1;

        // Asynchronous reset with both entries held.
        out_ready = 1'b0;
        send(32'h00812303, 32'h800, 4'hA);
        send(32'h00612623, 32'h804, 4'hB);
        #3; rst = 1'b1; #1;
        chk("arst.valid", out_valid, 1'b0);
        chk("arst.ready", in_ready, 1'b1);
        chk("arst.oper", out_oper, 8'h00);
        @(posedge clk); #1; rst = 1'b0;

        // Mixed tail with random consumer stalls.
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send(tbl[$urandom_range(0, 13)], 32'h1000 + 4 * i, 4'(i));
                tail_done = 1'b1;
            end
            begin
                while (!tail_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("end.drained", out_valid, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
